dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_arb_pkg.sv | 24 ++
 rtl/dma_channel_arbiter_rr.sv | 35 +++
 rtl/dma_channel_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA channel arbiter: FSM state encoding, descriptor
// field widths, and the packed descriptor that travels from a channel to
// the splitter configuration port.
package dma_arb_pkg;

  localparam int unsigned HOST_AW = 64;
  localparam int unsigned DEV_AW  = 32;
  localparam int unsigned SIZE_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [HOST_AW-1:0] host_addr;
    logic [DEV_AW-1:0]  dev_addr;
    logic [SIZE_W-1:0]  size;
    logic               dir_write;
  } ch_req_t;

endpackage

// File: rtl/dma_channel_arbiter_rr.sv
// Round-robin arbiter: purely combinational one-hot grant. The search
// starts at the channel after last_grant and wraps modulo NUM_CH, so the
// most recently served channel has the lowest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int LG_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [LG_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant
);

  logic          found;
  logic [LG_W:0] pos;

  // Walk the channels in priority order and keep the first requester.
  always_comb begin
    // NOTE: every variable gets a default before the loop, otherwise the
    // paths that never assign it would infer a latch.
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      pos = {1'b0, last_grant} + (LG_W+1)'(i);
      if (pos >= (LG_W+1)'(NUM_CH)) begin
        pos = pos - (LG_W+1)'(NUM_CH);
      end
      if (!found && req[pos[LG_W-1:0]]) begin
        grant[pos[LG_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: picks one requesting channel round-robin, latches its
// descriptor, issues it to the splitter with a one-cycle conf_valid strobe,
// waits for conf_transaction_done and returns a one-hot completion pulse.
// Zero-size requests are acknowledged and completed without an issue.
// Optional feature: define DMA_ARB_TIMEOUT_EN to add a WAIT watchdog that
// answers with ch_error instead of ch_done after TIMEOUT_CYC cycles.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*HOST_AW-1:0] ch_address_host,
  input  logic [NUM_CH*DEV_AW-1:0] ch_address_device,
  input  logic [NUM_CH*SIZE_W-1:0] ch_size,
  input  logic [NUM_CH-1:0]        ch_dir_write,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_error,
  output logic [HOST_AW-1:0]       conf_start_address_host,
  output logic [DEV_AW-1:0]        conf_start_address_device,
  output logic [SIZE_W-1:0]        conf_size,
  output logic                     conf_dir_write,
  output logic                     conf_valid,
  input  logic                     conf_transaction_done,
  output logic                     busy
);

  localparam int LG_W = $clog2(NUM_CH);

  // Out-of-range configurations stop elaboration instead of building a
  // silently broken arbiter.
  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("dma_channel_arbiter: NUM_CH must be 2..8 and TIMEOUT_CYC >= 1");
  end

  state_e            state_q, state_d;
  logic [LG_W-1:0]   last_grant_q, last_grant_d;
  logic [LG_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0] sel_oh_q, sel_oh_d;
  ch_req_t           req_q, req_d;
  ch_req_t           conf_q, conf_d;
  logic [NUM_CH-1:0] ch_ready_q, ch_ready_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic              conf_valid_q, conf_valid_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] grant;
  logic [LG_W-1:0]   grant_idx;
  ch_req_t           cand_req;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [NUM_CH-1:0] ch_error_q, ch_error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .LG_W   (LG_W)
  ) u_rr (
    .req        (ch_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Encode the one-hot grant and gather the winning channel's descriptor.
  always_comb begin
    grant_idx = '0;
    cand_req  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_idx          = LG_W'(i);
        cand_req.host_addr = ch_address_host[i*HOST_AW +: HOST_AW];
        cand_req.dev_addr  = ch_address_device[i*DEV_AW +: DEV_AW];
        cand_req.size      = ch_size[i*SIZE_W +: SIZE_W];
        cand_req.dir_write = ch_dir_write[i];
      end
    end
  end

  // FSM next-state and registered-output logic; pulses default to zero.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    sel_oh_d     = sel_oh_q;
    req_d        = req_q;
    conf_d       = conf_q;
    ch_ready_d   = '0;
    ch_done_d    = '0;
    conf_valid_d = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    ch_error_d   = '0;
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|ch_valid) begin
          sel_d      = grant_idx;
          sel_oh_d   = grant;
          req_d      = cand_req;
          ch_ready_d = grant;
          // Nothing to move: acknowledge and complete without a splitter issue.
          state_d    = (cand_req.size == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        conf_d       = req_q;
        conf_valid_d = 1'b1;
        state_d      = WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
      end
      WAIT: begin
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Completion is flagged on the way into RESP so ch_done trails the
        // splitter pulse by exactly one cycle.
        if (conf_transaction_done) begin
          ch_done_d = sel_oh_q;
          state_d   = RESP;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          ch_error_d = sel_oh_q;
          state_d    = RESP;
        end
`endif
      end
      RESP: begin
        // A zero-size request arrives here straight from IDLE and has not
        // been answered yet; the issued path already raised ch_done.
        if (req_q.size == '0) begin
          ch_done_d = sel_oh_q;
        end
        last_grant_d = sel_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= LG_W'(NUM_CH - 1);
      sel_q        <= '0;
      sel_oh_q     <= '0;
      req_q        <= '0;
      conf_q       <= '0;
      ch_ready_q   <= '0;
      ch_done_q    <= '0;
      conf_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      ch_error_q   <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the same edge regardless of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      sel_oh_q     <= sel_oh_d;
      req_q        <= req_d;
      conf_q       <= conf_d;
      ch_ready_q   <= ch_ready_d;
      ch_done_q    <= ch_done_d;
      conf_valid_q <= conf_valid_d;
      busy_q       <= busy_d;
`ifdef DMA_ARB_TIMEOUT_EN
      ch_error_q   <= ch_error_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ch_ready                  = ch_ready_q;
  assign ch_done                   = ch_done_q;
  assign conf_valid                = conf_valid_q;
  assign busy                      = busy_q;
  assign conf_start_address_host   = conf_q.host_addr;
  assign conf_start_address_device = conf_q.dev_addr;
  assign conf_size                 = conf_q.size;
  assign conf_dir_write            = conf_q.dir_write;

`ifdef DMA_ARB_TIMEOUT_EN
  assign ch_error = ch_error_q;
`else
  assign ch_error = '0;
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter (NUM_CH=4, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// The watchdog scenario is compiled in when DMA_ARB_TIMEOUT_EN is defined.
module tb_dma_channel_arbiter;

  localparam int NUM_CH = 4;

  logic                 i_clk;
  logic                 i_rst;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*64-1:0] ch_address_host;
  logic [NUM_CH*32-1:0] ch_address_device;
  logic [NUM_CH*32-1:0] ch_size;
  logic [NUM_CH-1:0]    ch_dir_write;
  logic [NUM_CH-1:0]    ch_ready;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_error;
  logic [63:0]          conf_start_address_host;
  logic [31:0]          conf_start_address_device;
  logic [31:0]          conf_size;
  logic                 conf_dir_write;
  logic                 conf_valid;
  logic                 conf_transaction_done;
  logic                 busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  dma_channel_arbiter #(
    .NUM_CH      (NUM_CH),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk                     (i_clk),
    .i_rst                     (i_rst),
    .ch_valid                  (ch_valid),
    .ch_address_host           (ch_address_host),
    .ch_address_device         (ch_address_device),
    .ch_size                   (ch_size),
    .ch_dir_write              (ch_dir_write),
    .ch_ready                  (ch_ready),
    .ch_done                   (ch_done),
    .ch_error                  (ch_error),
    .conf_start_address_host   (conf_start_address_host),
    .conf_start_address_device (conf_start_address_device),
    .conf_size                 (conf_size),
    .conf_dir_write            (conf_dir_write),
    .conf_valid                (conf_valid),
    .conf_transaction_done     (conf_transaction_done),
    .busy                      (busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [63:0] host, input logic [31:0] dev,
                        input logic [31:0] size, input logic dir);
    ch_address_host[ch*64 +: 64]   = host;
    ch_address_device[ch*32 +: 32] = dev;
    ch_size[ch*32 +: 32]           = size;
    ch_dir_write[ch]               = dir;
  endtask

  // Called in an IDLE cycle with ch_valid already driven; returns in the
  // IDLE cycle after RESP. The splitter answers `delay` cycles after the
  // conf_valid cycle.
  task automatic do_txn(input int ch, input logic [63:0] host, input logic [31:0] size,
                        input int delay, input string tag);
    step();
    check({tag, "_ready"}, 64'(ch_ready), 64'(1) << ch);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_early_cv"}, 64'(conf_valid), 64'd0);
    step();
    check({tag, "_conf_valid"}, 64'(conf_valid), 64'd1);
    check({tag, "_conf_size"}, 64'(conf_size), 64'(size));
    check({tag, "_conf_host"}, conf_start_address_host, host);
    check({tag, "_ready_gone"}, 64'(ch_ready), 64'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, "_wait_cv"}, 64'(conf_valid), 64'd0);
      check({tag, "_wait_done"}, 64'(ch_done), 64'd0);
    end
    conf_transaction_done = 1'b1;
    step();
    conf_transaction_done = 1'b0;
    check({tag, "_done"}, 64'(ch_done), 64'(1) << ch);
    check({tag, "_err"}, 64'(ch_error), 64'd0);
    step();
    check({tag, "_done_gone"}, 64'(ch_done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    i_rst                 = 1'b0;
    ch_valid              = '0;
    ch_address_host       = '0;
    ch_address_device     = '0;
    ch_size               = '0;
    ch_dir_write          = '0;
    conf_transaction_done = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ch_ready), 64'd0);
    check("rst_done", 64'(ch_done), 64'd0);
    check("rst_error", 64'(ch_error), 64'd0);
    check("rst_conf_valid", 64'(conf_valid), 64'd0);
    check("rst_conf_size", 64'(conf_size), 64'd0);
    check("rst_conf_host", conf_start_address_host, 64'd0);
    check("rst_conf_dev", 64'(conf_start_address_device), 64'd0);
    check("rst_conf_dir", 64'(conf_dir_write), 64'd0);
    i_rst = 1'b1;
    step();

    // Single request on channel 0, splitter answers 10 cycles after issue.
    set_ch(0, 64'h1000, 32'h2000, 32'h100, 1'b1);
    ch_valid = 4'b0001;
    check("t1_no_ready_yet", 64'(ch_ready), 64'd0);
    do_txn(0, 64'h1000, 32'h100, 10, "t1");
    ch_valid = 4'b0000;
    check("t1_hold_size", 64'(conf_size), 64'h100);
    check("t1_hold_dev", 64'(conf_start_address_device), 64'h2000);
    check("t1_hold_dir", 64'(conf_dir_write), 64'd1);

    // Fresh reset so channel 0 leads, then all four request continuously.
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, 64'h1000 * (i + 1), 32'h100 * (i + 1), 32'h10 * (i + 1), i[0]);
    end
    ch_valid = 4'b1111;
    do_txn(0, 64'h1000, 32'h10, 0, "rr0");
    do_txn(1, 64'h2000, 32'h20, 0, "rr1");
    do_txn(2, 64'h3000, 32'h30, 0, "rr2");
    do_txn(3, 64'h4000, 32'h40, 0, "rr3");
    do_txn(0, 64'h1000, 32'h10, 0, "rr4");

    // Lone requester keeps winning.
    ch_valid = 4'b0010;
    do_txn(1, 64'h2000, 32'h20, 2, "solo_a");
    do_txn(1, 64'h2000, 32'h20, 1, "solo_b");
    ch_valid = 4'b0000;

    // Zero-size request on channel 2: ready, no issue, done next cycle.
    set_ch(2, 64'h3000, 32'h300, 32'h0, 1'b0);
    ch_valid = 4'b0100;
    step();
    check("zs_ready", 64'(ch_ready), 64'b0100);
    check("zs_no_cv", 64'(conf_valid), 64'd0);
    check("zs_no_done_yet", 64'(ch_done), 64'd0);
    ch_valid = 4'b0000;
    step();
    check("zs_done", 64'(ch_done), 64'b0100);
    check("zs_no_cv2", 64'(conf_valid), 64'd0);
    check("zs_conf_hold", 64'(conf_size), 64'h20);
    step();
    check("zs_done_gone", 64'(ch_done), 64'd0);
    check("zs_idle", 64'(busy), 64'd0);

    // Stray splitter completion while idle is ignored.
    conf_transaction_done = 1'b1;
    step();
    conf_transaction_done = 1'b0;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_done", 64'(ch_done), 64'd0);
    step();
    check("stray_done2", 64'(ch_done), 64'd0);
    check("stray_ready", 64'(ch_ready), 64'd0);

    // Reset during WAIT aborts silently; channel 0 wins next.
    set_ch(2, 64'h3000, 32'h300, 32'h30, 1'b0);
    ch_valid = 4'b0100;
    step();
    check("ab_ready", 64'(ch_ready), 64'b0100);
    ch_valid = 4'b0000;
    step();
    check("ab_cv", 64'(conf_valid), 64'd1);
    step();
    step();
    check("ab_waiting", 64'(busy), 64'd1);
    i_rst = 1'b0;
    #1;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_conf_size", 64'(conf_size), 64'd0);
    step();
    check("ab_no_done", 64'(ch_done), 64'd0);
    step();
    check("ab_no_done2", 64'(ch_done), 64'd0);
    i_rst = 1'b1;
    ch_valid = 4'b1111;
    do_txn(0, 64'h1000, 32'h10, 0, "ab_next");
    ch_valid = 4'b0000;

`ifdef DMA_ARB_TIMEOUT_EN
    // Watchdog: channel 3 issued, splitter never answers.
    ch_valid = 4'b1000;
    step();
    check("to_ready", 64'(ch_ready), 64'b1000);
    ch_valid = 4'b0000;
    step();
    check("to_cv", 64'(conf_valid), 64'd1);
    for (int k = 0; k < 17; k++) begin
      check("to_no_err", 64'(ch_error), 64'd0);
      check("to_no_done", 64'(ch_done), 64'd0);
      step();
    end
    check("to_err", 64'(ch_error), 64'b1000);
    check("to_done_low", 64'(ch_done), 64'd0);
    step();
    check("to_err_gone", 64'(ch_error), 64'd0);
    check("to_idle", 64'(busy), 64'd0);
    check("to_done_low2", 64'(ch_done), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
